// File: rtl/seq_local_pkg.sv
// Shared constants, slot-state type and small helpers for the local-variable
// sequence scheduler.
//   DEF_NSLOT / DEF_DW / DEF_CW : default slot count, capture width, counter width
//   NO_SLOT                     : value returned by lowest_free when nothing is free
//   slot_state_t                : control state of one attempt slot
//   lowest_free()               : index of the lowest set bit of an 8-bit free mask
//   popcount8()                 : number of set bits in an 8-bit vector
package seq_local_pkg;

    localparam int unsigned DEF_NSLOT = 4;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_CW    = 16;

    // Slot count never exceeds 8, so 8 means "no free slot".
    localparam logic [3:0] NO_SLOT = 4'd8;

    // Control part of a slot; the captured value lives next to it because
    // its width follows the DW parameter of the instantiating block.
    typedef struct packed {
        logic       busy;
        logic [3:0] cnt;
    } slot_state_t;

    function automatic logic [3:0] lowest_free(input logic [7:0] free);
        lowest_free = NO_SLOT;
        for (int unsigned i = 0; i < 8; i++) begin
            if (free[i] && (lowest_free == NO_SLOT)) begin
                lowest_free = 4'(i);
            end
        end
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        popcount8 = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            popcount8 = popcount8 + {3'b000, v[i]};
        end
    endfunction

endpackage

// File: rtl/seq_local_sched_if.sv
// Bundle of the scheduler's attempt inputs and result outputs.
//   start_i, data_i, delay_i, check_i, disable_i : stimulus (master -> slave)
//   match_o, fail_o, overflow_o, active_o,
//   match_cnt_o, fail_cnt_o                       : results (slave -> master)
interface seq_local_sched_if
    import seq_local_pkg::*;
#(
    parameter int unsigned NSLOT = DEF_NSLOT,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned CW    = DEF_CW
);
    logic             start_i;
    logic [DW-1:0]    data_i;
    logic [3:0]       delay_i;
    logic [DW-1:0]    check_i;
    logic             disable_i;
    logic [NSLOT-1:0] match_o;
    logic [NSLOT-1:0] fail_o;
    logic             overflow_o;
    logic [NSLOT-1:0] active_o;
    logic [CW-1:0]    match_cnt_o;
    logic [CW-1:0]    fail_cnt_o;

    modport master (
        output start_i, data_i, delay_i, check_i, disable_i,
        input  match_o, fail_o, overflow_o, active_o, match_cnt_o, fail_cnt_o
    );

    modport slave (
        input  start_i, data_i, delay_i, check_i, disable_i,
        output match_o, fail_o, overflow_o, active_o, match_cnt_o, fail_cnt_o
    );
endinterface

// File: rtl/seq_local_slot.sv
// One sequence-attempt slot: captures a local value on allocation, counts
// down to its check edge, then compares and pulses match or fail.
//   clk, rst_n          : clock, asynchronous active-low reset
//   alloc               : load this slot at this edge
//   abort               : disable-iff; drop the attempt without a result
//   data, delay, check  : capture value, check distance, compare value
//   busy                : registered slot-occupied flag
//   done                : this edge is the check edge (slot frees itself)
//   hit_match, hit_fail : result being registered at this edge
//   match, fail         : registered one-cycle result pulses
module seq_local_slot
    import seq_local_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc,
    input  logic          abort,
    input  logic [DW-1:0] data,
    input  logic [3:0]    delay,
    input  logic [DW-1:0] check,
    output logic          busy,
    output logic          done,
    output logic          hit_match,
    output logic          hit_fail,
    output logic          match,
    output logic          fail
);
    slot_state_t   st;
    logic [DW-1:0] cap;
    logic [3:0]    load_cnt;

    always_comb begin
        load_cnt  = (delay == 4'd0) ? 4'd1 : delay;
        done      = st.busy && (st.cnt == 4'd1);
        hit_match = done && !abort && (cap == check);
        hit_fail  = done && !abort && (cap != check);
    end

    assign busy = st.busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= '0;
            cap   <= '0;
            match <= 1'b0;
            fail  <= 1'b0;
        end else begin
            match <= hit_match;
            fail  <= hit_fail;
            if (abort) begin
                st.busy <= 1'b0;
            end else if (alloc) begin
                // Allocation may coincide with this slot's own check edge;
                // the old result is still registered above.
                st.busy <= 1'b1;
                st.cnt  <= load_cnt;
                cap     <= data;
            end else if (done) begin
                st.busy <= 1'b0;
            end else if (st.busy) begin
                st.cnt <= st.cnt - 4'd1;
            end
        end
    end
endmodule

// File: rtl/seq_local_sched.sv
// Scheduler for concurrent sequence attempts with a captured local variable.
// Allocates starts to the lowest free slot, reports per-slot results and
// keeps saturating match/fail counts.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seq_local_sched_if slave (attempt inputs, result outputs)
module seq_local_sched
    import seq_local_pkg::*;
#(
    parameter int unsigned NSLOT = DEF_NSLOT,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_local_sched_if.slave  bus
);
    logic [NSLOT-1:0] busy;
    logic [NSLOT-1:0] done;
    logic [NSLOT-1:0] alloc;
    logic [NSLOT-1:0] hit_match;
    logic [NSLOT-1:0] hit_fail;
    logic [NSLOT-1:0] match_q;
    logic [NSLOT-1:0] fail_q;
    logic [7:0]       free8;
    logic [7:0]       hm8;
    logic [7:0]       hf8;
    logic [3:0]       free_idx;
    logic             take;
    logic             drop;
    logic             overflow_q;
    logic [CW-1:0]    match_cnt;
    logic [CW-1:0]    fail_cnt;
    logic [CW:0]      match_sum;
    logic [CW:0]      fail_sum;

    always_comb begin
        // A slot at its check edge is reusable by a start at the same edge.
        free8            = '0;
        free8[NSLOT-1:0] = ~busy | done;
        free_idx         = lowest_free(free8);
        take             = bus.start_i && !bus.disable_i;
        drop             = take && (free_idx == NO_SLOT);
        alloc            = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            alloc[i] = take && (free_idx == 4'(i));
        end
        hm8              = '0;
        hm8[NSLOT-1:0]   = hit_match;
        hf8              = '0;
        hf8[NSLOT-1:0]   = hit_fail;
        // One extra bit catches any step past the top of the count range.
        match_sum = {1'b0, match_cnt} + (CW+1)'(popcount8(hm8));
        fail_sum  = {1'b0, fail_cnt}  + (CW+1)'(popcount8(hf8));
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        seq_local_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .alloc     (alloc[g]),
            .abort     (bus.disable_i),
            .data      (bus.data_i),
            .delay     (bus.delay_i),
            .check     (bus.check_i),
            .busy      (busy[g]),
            .done      (done[g]),
            .hit_match (hit_match[g]),
            .hit_fail  (hit_fail[g]),
            .match     (match_q[g]),
            .fail      (fail_q[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            match_cnt  <= '0;
            fail_cnt   <= '0;
        end else begin
            overflow_q <= drop;
            match_cnt  <= match_sum[CW] ? '1 : match_sum[CW-1:0];
            fail_cnt   <= fail_sum[CW]  ? '1 : fail_sum[CW-1:0];
        end
    end

    assign bus.match_o     = match_q;
    assign bus.fail_o      = fail_q;
    assign bus.active_o    = busy;
    assign bus.overflow_o  = overflow_q;
    assign bus.match_cnt_o = match_cnt;
    assign bus.fail_cnt_o  = fail_cnt;
endmodule

// File: tb/tb_seq_local_sched.sv
// Self-checking bench for seq_local_sched: directed scenarios plus random
// traffic, compared every cycle against a queue-of-attempts reference model.
module tb_seq_local_sched;
    localparam int unsigned NSLOT = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 16;
    localparam int          CMAX  = 65535;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_local_sched_if #(.NSLOT(NSLOT), .DW(DW), .CW(CW)) bus ();

    seq_local_sched #(.NSLOT(NSLOT), .DW(DW), .CW(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: list of outstanding attempts with absolute due edges.
    typedef struct {
        int         slot;
        logic [7:0] data;
        int         due;
    } attempt_t;

    attempt_t   pend[$];
    int         cyc;
    logic [3:0] e_match;
    logic [3:0] e_fail;
    logic [3:0] e_active;
    logic       e_ovf;
    int         e_mcnt;
    int         e_fcnt;
    int         n_checks;
    int         n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        pend.delete();
        e_match  = '0;
        e_fail   = '0;
        e_active = '0;
        e_ovf    = 1'b0;
        e_mcnt   = 0;
        e_fcnt   = 0;
    endtask

    task automatic model_edge(input logic st, input logic [7:0] d, input logic [3:0] dl,
                              input logic [7:0] ck, input logic dis);
        logic [3:0] occ;
        int         pick;
        cyc++;
        e_match = '0;
        e_fail  = '0;
        e_ovf   = 1'b0;
        if (dis) begin
            pend.delete();
        end else begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    if (pend[i].data == ck) e_match[pend[i].slot] = 1'b1;
                    else                    e_fail[pend[i].slot]  = 1'b1;
                    pend.delete(i);
                end
            end
            e_mcnt += $countones(e_match);
            e_fcnt += $countones(e_fail);
            if (e_mcnt > CMAX) e_mcnt = CMAX;
            if (e_fcnt > CMAX) e_fcnt = CMAX;
            if (st) begin
                occ = '0;
                foreach (pend[i]) occ[pend[i].slot] = 1'b1;
                pick = -1;
                for (int s = NSLOT - 1; s >= 0; s--) if (!occ[s]) pick = s;
                if (pick < 0) e_ovf = 1'b1;
                else pend.push_back('{pick, d, cyc + ((dl == 4'd0) ? 1 : int'(dl))});
            end
        end
        e_active = '0;
        foreach (pend[i]) e_active[pend[i].slot] = 1'b1;
    endtask

    task automatic compare_all();
        check("match_o",     32'(bus.match_o),     32'(e_match));
        check("fail_o",      32'(bus.fail_o),      32'(e_fail));
        check("active_o",    32'(bus.active_o),    32'(e_active));
        check("overflow_o",  32'(bus.overflow_o),  32'(e_ovf));
        check("match_cnt_o", 32'(bus.match_cnt_o), 32'(e_mcnt));
        check("fail_cnt_o",  32'(bus.fail_cnt_o),  32'(e_fcnt));
    endtask

    task automatic step(input logic st, input logic [7:0] d, input logic [3:0] dl,
                        input logic [7:0] ck, input logic dis);
        bus.start_i   = st;
        bus.data_i    = d;
        bus.delay_i   = dl;
        bus.check_i   = ck;
        bus.disable_i = dis;
        @(posedge clk);
        model_edge(st, d, dl, ck, dis);
        #1;
        compare_all();
    endtask

    // Reset asserted between edges, held across an edge with a start pending.
    task automatic do_reset();
        rst_n         = 1'b0;
        bus.start_i   = 1'b1;
        bus.data_i    = 8'hAA;
        bus.delay_i   = 4'd1;
        bus.check_i   = 8'hAA;
        bus.disable_i = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        do_reset();

        // Single match with delay 1, accepted on the first edge after reset.
        step(1'b1, 8'h5A, 4'd1, 8'h00, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'h5A, 1'b0);
        check("d1_match_bit", 32'(bus.match_o), 32'h1);
        check("d1_match_cnt", 32'(bus.match_cnt_o), 32'h1);

        // Fail after delay 3; only the third edge reports.
        step(1'b1, 8'h10, 4'd3, 8'h00, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'h10, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'h10, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'h11, 1'b0);
        check("d3_fail_bit", 32'(bus.fail_o), 32'h1);
        check("d3_fail_cnt", 32'(bus.fail_cnt_o), 32'h1);

        // All slots busy, fifth start dropped.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 4'd8, 8'h00, 1'b0);
        step(1'b1, 8'h77, 4'd8, 8'h00, 1'b0);
        check("ovf_pulse", 32'(bus.overflow_o), 32'h1);
        check("ovf_active", 32'(bus.active_o), 32'hF);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 4'd0, 8'(8'h40 + i - 3), 1'b0);

        // Slot 0 completes and is reallocated on the same edge.
        step(1'b1, 8'h21, 4'd2, 8'h00, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'h00, 1'b0);
        step(1'b1, 8'h22, 4'd1, 8'h21, 1'b0);
        check("realloc_no_ovf", 32'(bus.overflow_o), 32'h0);
        check("realloc_match", 32'(bus.match_o), 32'h1);
        step(1'b0, 8'h00, 4'd0, 8'h22, 1'b0);

        // Disable with three busy slots.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h33, 4'd5, 8'h00, 1'b0);
        step(1'b0, 8'h00, 4'd0, 8'h33, 1'b1);
        check("dis_active", 32'(bus.active_o), 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 4'd0, 8'h33, 1'b0);

        // Reset mid-attempt.
        step(1'b1, 8'h55, 4'd4, 8'h00, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 4'd0, 8'h55, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] dl;
            dl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) do_reset();
            step(1'($urandom_range(0, 9) < 6), 8'($urandom_range(0, 3)), dl,
                 8'($urandom_range(0, 3)), 1'($urandom_range(0, 49) == 0));
        end

        // Saturation: one match per edge until the count pins at the top.
        do_reset();
        for (int i = 0; i < CMAX + 5; i++) step(1'b1, 8'h3C, 4'd1, 8'h3C, 1'b0);
        check("sat_match_cnt", 32'(bus.match_cnt_o), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_local_sched.md
SEQ_LOCAL_SCHED -- requirements
Module: seq_local_sched

Interface
REQ-001 Parameter NSLOT, default 4, number of concurrent sequence attempts (2..8).
REQ-002 Parameter DW, default 8, width of captured local variable.
REQ-003 Parameter CW, default 16, width of match/fail counters.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  attempt start; the sequence antecedent is true this edge.
- data_i  in  DW  value captured into the attempt's local variable at start.
- delay_i  in  4  cycles from start to check edge; 0 treated as 1.
- check_i  in  DW  value compared against the captured local at the check edge.
- disable_i  in  1  disable-iff condition; aborts all attempts silently.
- match_o  out  NSLOT  per-slot one-cycle pulse: captured == check_i.
- fail_o  out  NSLOT  per-slot one-cycle pulse: captured != check_i.
- overflow_o  out  1  one-cycle pulse: start dropped because no slot was free.
- active_o  out  NSLOT  slot-busy vector.
- match_cnt_o  out  CW  saturating count of matches.
- fail_cnt_o  out  CW  saturating count of failures.

Function
REQ-005 Each slot SHALL hold: busy flag, captured value (DW), down-counter (4 bits).
REQ-006 Start: when start_i=1 and disable_i=0 at edge t, the lowest-index free slot SHALL become busy, capture data_i, and load the counter with max(delay_i,1).
REQ-007 Each busy slot SHALL decrement its counter every edge after allocation; the edge at which the counter reaches 1 is the check edge (t+delay).
REQ-008 At the check edge, the slot SHALL compare captured against check_i sampled at that edge, pulse match_o[i] or fail_o[i] for exactly one cycle after that edge, and clear busy.
REQ-009 A slot completing at edge e SHALL count as free for a start at the same edge e.
REQ-010 Several slots completing at the same edge SHALL each pulse their own match_o/fail_o bits; counters SHALL add the population count of each.
REQ-011 If no slot is free at a start edge (after REQ-009), the start SHALL be dropped and overflow_o SHALL pulse for one cycle; no existing slot is disturbed.
REQ-012 disable_i=1 at any edge SHALL clear all busy flags, suppress all match/fail pulses and any start at that edge, and leave the counters unchanged.
REQ-013 match_cnt_o and fail_cnt_o SHALL saturate at 2^CW-1; they never wrap.
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-015 On rst_n=0, asynchronously: all slots free, captured values 0, counters 0.
REQ-016 While rst_n=0, match_o, fail_o, active_o and overflow_o SHALL be 0, and match_cnt_o and fail_cnt_o SHALL be 0.
REQ-017 Reset asserted mid-attempt SHALL abort all attempts with no pulse.
REQ-018 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-019 Package seq_local_pkg SHALL hold the default NSLOT/DW/CW constants, the slot-state struct typedef, and a lowest-free-index function.
REQ-020 One sub-module, seq_local_slot, SHALL implement a single slot (REQ-005..REQ-008); the top SHALL instantiate NSLOT copies plus the allocator and counters.

Verification
REQ-021 Start with data_i=8'h5A and delay_i=1; at the next edge check_i=8'h5A -> match_o[0] pulses once, match_cnt_o=1.
REQ-022 Start with data_i=8'h10 and delay_i=3; check_i=8'h11 at t+3 -> fail_o[0] pulses once at t+3 only, fail_cnt_o=1.
REQ-023 Four starts on consecutive edges with delay_i=8, then a fifth start -> overflow_o pulses, active_o=4'b1111, and the first four attempts still report.
REQ-024 Slot 0 completes at edge e while a new start occurs at e -> slot 0 is reallocated with no overflow, and the old and new results are both correct.
REQ-025 Three slots busy, disable_i=1 for one edge -> active_o=0, no match/fail pulses, counters unchanged.
REQ-026 Preset match_cnt_o to 16'hFFFF by forcing 65535 matches (CW=16), then one more match -> match_cnt_o stays 16'hFFFF.
